ws_frame_buffer: RTL

//  Double-banked pixel store feeding the WS2812 serial driver. A host writes a

---
 rtl/ws_frame_buffer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ws_frame_buffer.sv
// ws_frame_buffer: double-banked 24-bit pixel store for the WS2812 driver.
// The host fills the back bank and commits it. The banks swap at the next frame start.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   wr_valid/wr_ready   host pixel write handshake (wr_addr, wr_data)
//   commit              pulse: back bank complete, swap at next frame start
//   commit_pending      commit registered, swap not yet done
//   commit_done         one-cycle pulse in the cycle the new bank takes effect
//   brightness          global scale, captured with each driver request
//   new_data_req        driver request level; a rising edge launches a read
//   current_ledN        driver pixel index, captured at the request edge
//   color_rgb           {8'h00,B,G,R}, scaled pixel, valid 3 cycles after capture
module ws_frame_buffer #(
    parameter int LEDS_NUM = 7,
    parameter int ADDR_W   = $clog2(LEDS_NUM + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              commit,
    output logic              commit_pending,
    output logic              commit_done,
    input  logic [7:0]        brightness,
    input  logic              new_data_req,
    input  logic [ADDR_W-1:0] current_ledN,
    output logic [31:0]       color_rgb
);

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        RUN    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LEDS_NUM - 1);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(LEDS_NUM);

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] clr_cnt;
    logic              front_sel;
    logic              req_q;

    logic rise;
    logic frame_start;
    logic swap;
    logic commit_take;
    logic wr_fire;
    logic wr_in_range;

    logic [23:0] bank0 [LEDS_NUM];
    logic [23:0] bank1 [LEDS_NUM];

    // Read pipeline: s1 = captured request, s2 = RAM data, s3 = scaled pixel.
    logic              s1_vld;
    logic [ADDR_W-1:0] s1_idx;
    logic [7:0]        s1_bri;
    logic              s1_sel;
    logic              s1_blank;

    logic              s2_vld;
    logic [23:0]       s2_pix;
    logic [7:0]        s2_bri;

    logic              s3_vld;
    logic [23:0]       s3_rgb;

    logic [ADDR_W-1:0] rd_idx;
    logic [23:0]       rd_pix;

    function automatic logic [7:0] scale8(
        input logic [7:0] ch,
        input logic [7:0] bri
    );
        scale8 = 8'((16'(ch) * (16'(bri) + 16'd1)) >> 8);
    endfunction

    assign rise        = new_data_req && !req_q;
    assign frame_start = rise && (current_ledN == '0);
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = wr_addr < LIMIT;

    always_comb begin
        state_nxt   = state;
        wr_ready    = 1'b0;
        swap        = 1'b0;
        commit_take = 1'b0;
        unique case (state)
            CLEAR: begin
                if (clr_cnt == LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                wr_ready = 1'b1;
                if (commit) begin
                    commit_take = 1'b1;
                    state_nxt   = LOCKED;
                end
            end
            LOCKED: begin
                if (frame_start) begin
                    swap      = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= CLEAR;
            clr_cnt        <= '0;
            front_sel      <= 1'b0;
            req_q          <= 1'b0;
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
        end else begin
            state       <= state_nxt;
            req_q       <= new_data_req;
            commit_done <= swap;
            if (state == CLEAR && clr_cnt != LAST) begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
            end
            if (swap) begin
                front_sel <= ~front_sel;
            end
            if (commit_take) begin
                commit_pending <= 1'b1;
            end else if (swap) begin
                commit_pending <= 1'b0;
            end
        end
    end

    // Clear wipes both banks; host writes only ever touch the back bank.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                bank0[clr_cnt] <= '0;
                bank1[clr_cnt] <= '0;
            end else if (wr_fire && wr_in_range) begin
                if (front_sel) begin
                    bank0[wr_addr] <= wr_data;
                end else begin
                    bank1[wr_addr] <= wr_data;
                end
            end
        end
    end

    assign rd_idx = s1_blank ? '0 : s1_idx;
    assign rd_pix = s1_sel ? bank1[rd_idx] : bank0[rd_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_vld    <= 1'b0;
            s1_idx    <= '0;
            s1_bri    <= '0;
            s1_sel    <= 1'b0;
            s1_blank  <= 1'b0;
            s2_vld    <= 1'b0;
            s2_pix    <= '0;
            s2_bri    <= '0;
            s3_vld    <= 1'b0;
            s3_rgb    <= '0;
            color_rgb <= '0;
        end else begin
            s1_vld <= rise;
            if (rise) begin
                s1_idx   <= current_ledN;
                s1_bri   <= brightness;
                // A swapping edge already reads from the new front bank.
                s1_sel   <= front_sel ^ swap;
                s1_blank <= (state == CLEAR) || (current_ledN >= LIMIT);
            end

            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_pix <= s1_blank ? 24'h0 : rd_pix;
                s2_bri <= s1_bri;
            end

            s3_vld <= s2_vld;
            if (s2_vld) begin
                s3_rgb <= {scale8(s2_pix[23:16], s2_bri),
                           scale8(s2_pix[15:8], s2_bri),
                           scale8(s2_pix[7:0], s2_bri)};
            end

            if (s3_vld) begin
                color_rgb <= {8'h00, s3_rgb};
            end
        end
    end

endmodule
